mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial memory controller between the 8-bit unified RAM port and the two memory clients: the instruction fetch unit (64-byte I-cache line refills) and the load/store buffer (1/2/4-byte loads and stores). One transaction is in flight at a time, arbitrated from an IDLE state with LSB priority. Results return as a single-cycle `done` pulse with registered data.

## Interface
- `IF_LINE_BYTES`, 64: bytes per I-cache line; `if_data` width is 8×this (`IF_DATA_WID`).
- `ADDR_W`, 32: address width (`ADDR_WID`).
- `IO_HI`, 2'b11: value of `addr[17:16]` marking the I/O region.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; low means freeze.
- `mem_din` in 8: RAM read byte, valid one cycle after its address.
- `mem_dout` out 8: RAM write byte.
- `mem_a` out 32: RAM byte address.
- `mem_wr` out 1: 1 = write, 0 = read.
- `io_buffer_full` in 1: UART buffer full.
- `if_en` in 1: line-read request, held until done or abandoned.
- `if_pc` in 32: line base address, 64-byte aligned.
- `if_done` out 1: one-cycle pulse, line valid.
- `if_data` out 512: line data; byte k at bits [8k+7:8k].
- `lsb_en` in 1: load/store request, held until `lsb_done`.
- `lsb_wr` in 1: 1 = store.
- `lsb_addr` in 32: first byte address.
- `lsb_len` in 3: byte count, one of 1, 2 or 4.
- `lsb_w_data` in 32: store data, little-endian, low bytes used.
- `lsb_done` out 1: one-cycle pulse.
- `lsb_r_data` out 32: load data, zero-extended above `lsb_len` bytes.

## Operation
- States: IDLE, IF_RD, LS_RD, LS_WR.
- Counters: issue index `iss` and capture index `cap`, both 7 bits. One flag `pend` means a read address was issued in the previous cycle.
- IDLE transitions:
  - `lsb_en` → LS_WR if `lsb_wr`, else LS_RD. Latch addr/len/data.
  - else `if_en` → IF_RD. Latch `if_pc`.
  - Clear `iss`, `cap`, `pend`.
  - No request is accepted in a cycle where `if_done` or `lsb_done` is high (the requester's `en` is still high then).
- Reads (IF_RD and LS_RD), each cycle:
  - if `iss < N`: drive `mem_a = base + iss`, `iss++`, `pend <= 1`; else `pend <= 0`.
  - if `pend`: store `mem_din` into byte `cap`, `cap++`.
  - When the last byte is captured, raise `done` and go to IDLE.
  - N = 64 for IF, `lsb_len` for LS.
- Writes (LS_WR), each cycle:
  - drive `mem_wr = 1`, `mem_a = base + iss`, `mem_dout = byte iss`, `iss++`.
  - After byte N-1 is written, raise `lsb_done` next cycle and go to IDLE.
  - I/O stall: if `lsb_addr[17:16] == IO_HI` and `io_buffer_full`, drive `mem_wr = 0` and `mem_a = 0`, and hold `iss`.
- Abandon: if `if_en` is low during IF_RD, go to IDLE next cycle. No `if_done`; `if_data` is don't-care. LSB requests are never abandoned.
- Simultaneous `if_en` and `lsb_en` in IDLE: LSB wins; IF waits.
- `rdy` = 0: all state and counters hold, `mem_wr = 0`, `pend` clears. On resume, reads re-issue from `cap` (set `iss <= cap`), so no byte is lost or duplicated. Writes resume at `iss`; a stalled byte is never written twice.
- Address arithmetic is a 32-bit add that wraps silently; alignment is not checked.

## Timing
- Reset values: state IDLE, `mem_wr` 0, `mem_a` 0, `mem_dout` 0, `if_done` 0, `lsb_done` 0, `if_data` 0, `lsb_r_data` 0, counters 0.
- `mem_wr`, `mem_a` and `mem_dout` are combinational from state/counters; `done` and data outputs are registered.
- Latency, request seen in IDLE at cycle 0, no stalls:
  - IF line: first address at cycle 1, `if_done` at cycle 66.
  - LS load of n bytes: `lsb_done` at cycle n+2.
  - LS store of n bytes: `lsb_done` at cycle n+1.
- `done` is high exactly one cycle. Data is stable from the `done` cycle until the next transaction of the same client completes.
- `rst` mid-transaction: IDLE next cycle; no `done` is emitted for the killed transaction.

## Structure
- Add to `macros.v`: `IF_DATA_WID` (511:0), `IO_ADDR_RANGE` (17:16), and state encodings `MC_IDLE`, `MC_IF_RD`, `MC_LS_RD`, `MC_LS_WR`.
- Single module, no sub-modules. Byte insertion into `if_data` and `lsb_r_data` is an indexed part-select on `cap`.

## Test plan
- Line fill: RAM[0x1000+k] = k; `if_en` with `if_pc = 0x1000` → `if_done` at cycle 66 and `if_data[31:0] = 0x03020100`.
- Word load: RAM holds 0x78,0x56,0x34,0x12 at 0x200, `lsb_len = 4` → `lsb_r_data = 0x12345678`. Same address with `lsb_len = 1` → 0x00000078.
- Half store: `lsb_w_data = 0xAABBCCDD`, `lsb_len = 2` at 0x300 → two writes 0xDD@0x300 and 0xCC@0x301; 0x302 unchanged; `lsb_done` at cycle 3.
- Arbitration: `if_en` and `lsb_en` both rise in the same cycle → LSB served first; IF starts after `lsb_done` plus one cycle; each done pulses once.
- Abandon/freeze: drop `if_en` at byte 20 → no `if_done`, LSB is accepted next. Hold `rdy = 0` for 5 cycles at byte 30 of a fill → final line is identical to the unstalled fill.
- I/O stall: store 1 byte to 0x30000 with `io_buffer_full = 1` for 4 cycles → `mem_wr` stays 0 for those cycles, then one write, then `lsb_done`.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: widths, I/O region code and state encodings for mem_ctrl
//   IF_LINE_BYTES/IF_DATA_WID: I-cache line size in bytes / bits
//   ADDR_WID: byte address width; IO_HI: addr[17:16] value of the I/O region
package mem_ctrl_pkg;
  localparam int IF_LINE_BYTES = 64;
  localparam int IF_DATA_WID = 8 * IF_LINE_BYTES;
  localparam int ADDR_WID = 32;
  localparam logic [1:0] IO_HI = 2'b11;
  localparam logic [1:0] MC_IDLE = 2'd0;
  localparam logic [1:0] MC_IF_RD = 2'd1;
  localparam logic [1:0] MC_LS_RD = 2'd2;
  localparam logic [1:0] MC_LS_WR = 2'd3;
  function automatic logic is_io(input logic [ADDR_WID-1:0] a);
    return a[17:16] == IO_HI;
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller serving I-cache line fills and LSB loads/stores
//   clk/rst/rdy: clock, sync active-high reset, global enable (low = freeze)
//   mem_din/mem_dout/mem_a/mem_wr: 8-bit RAM port, read data one cycle after address
//   io_buffer_full: UART full, stalls stores into the I/O region
//   if_en/if_pc -> if_done/if_data: 64-byte line read
//   lsb_en/lsb_wr/lsb_addr/lsb_len/lsb_w_data -> lsb_done/lsb_r_data: 1/2/4-byte access
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [ADDR_WID-1:0]    mem_a,
  output logic                   mem_wr,
  input  logic                   io_buffer_full,
  input  logic                   if_en,
  input  logic [ADDR_WID-1:0]    if_pc,
  output logic                   if_done,
  output logic [IF_DATA_WID-1:0] if_data,
  input  logic                   lsb_en,
  input  logic                   lsb_wr,
  input  logic [ADDR_WID-1:0]    lsb_addr,
  input  logic [2:0]             lsb_len,
  input  logic [31:0]            lsb_w_data,
  output logic                   lsb_done,
  output logic [31:0]            lsb_r_data
);
  logic [1:0] state;
  logic [6:0] iss, cap, n;
  logic pend, rd, issue, stall, last_cap, last_wr;
  logic [ADDR_WID-1:0] base;
  logic [2:0] ls_len;
  logic [31:0] ls_wdat, ls_buf, ls_nxt;
  logic [IF_DATA_WID-1:0] line_buf, line_nxt;
  always_comb begin
    rd = state == MC_IF_RD || state == MC_LS_RD;
    n = state == MC_IF_RD ? 7'(IF_LINE_BYTES) : {4'd0, ls_len};
    issue = rd && iss < n;
    stall = is_io(base) && io_buffer_full;
    last_cap = rd && pend && cap == n - 7'd1;
    last_wr = state == MC_LS_WR && !stall && iss == n - 7'd1;
    mem_wr = rdy && state == MC_LS_WR && !stall;
    mem_a = issue || mem_wr ? base + {{(ADDR_WID-7){1'b0}}, iss} : '0;
    mem_dout = mem_wr ? ls_wdat[{iss[1:0], 3'b000} +: 8] : 8'd0;
    line_nxt = line_buf;
    line_nxt[{cap[5:0], 3'b000} +: 8] = mem_din;
    ls_nxt = ls_buf;
    ls_nxt[{cap[1:0], 3'b000} +: 8] = mem_din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MC_IDLE;
      iss <= '0;
      cap <= '0;
      pend <= 1'b0;
      base <= '0;
      ls_len <= '0;
      ls_wdat <= '0;
      ls_buf <= '0;
      line_buf <= '0;
      if_done <= 1'b0;
      lsb_done <= 1'b0;
      if_data <= '0;
      lsb_r_data <= '0;
    end else begin
      if_done <= 1'b0;
      lsb_done <= 1'b0;
      if (!rdy) begin
        // the byte in flight is dropped; reads restart from the first uncaptured byte
        pend <= 1'b0;
        if (rd) iss <= cap;
      end else if (state == MC_IDLE) begin
        iss <= '0;
        cap <= '0;
        pend <= 1'b0;
        ls_buf <= '0;
        // requester's en is still high during its done cycle, so ignore it then
        if (!if_done && !lsb_done) begin
          if (lsb_en) begin
            state <= lsb_wr ? MC_LS_WR : MC_LS_RD;
            base <= lsb_addr;
            ls_len <= lsb_len;
            ls_wdat <= lsb_w_data;
          end else if (if_en) begin
            state <= MC_IF_RD;
            base <= if_pc;
          end
        end
      end else if (state == MC_IF_RD && !if_en) begin
        state <= MC_IDLE;
      end else if (rd) begin
        iss <= issue ? iss + 7'd1 : iss;
        pend <= issue;
        if (pend) begin
          cap <= cap + 7'd1;
          if (state == MC_IF_RD) line_buf <= line_nxt;
          else ls_buf <= ls_nxt;
        end
        if (last_cap) begin
          state <= MC_IDLE;
          if (state == MC_IF_RD) begin
            if_done <= 1'b1;
            if_data <= line_nxt;
          end else begin
            lsb_done <= 1'b1;
            lsb_r_data <= ls_nxt;
          end
        end
      end else if (!stall) begin
        iss <= iss + 7'd1;
        if (last_wr) begin
          state <= MC_IDLE;
          lsb_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a byte-array memory model
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, io_buffer_full = 1'b0;
  logic [7:0] mem_din, mem_dout;
  logic [31:0] mem_a;
  logic mem_wr;
  logic if_en = 1'b0, if_done;
  logic [31:0] if_pc = '0;
  logic [IF_DATA_WID-1:0] if_data;
  logic lsb_en = 1'b0, lsb_wr = 1'b0, lsb_done;
  logic [31:0] lsb_addr = '0, lsb_w_data = '0, lsb_r_data;
  logic [2:0] lsb_len = 3'd1;
  logic [7:0] ram [0:262143];
  logic [7:0] ref_mem [0:262143];
  logic poke_en = 1'b0;
  logic [17:0] poke_a = '0;
  logic [7:0] poke_d = '0;
  int checks = 0, errors = 0, wr_cnt = 0, ifd_cnt = 0, lsd_cnt = 0;
  always #5 clk = ~clk;
  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data)
  );
  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 131) ^ (i >> 5));
  endfunction
  initial begin
    for (int i = 0; i < 262144; i++) ram[i] = init_byte(i);
    forever begin
      @(posedge clk);
      if (poke_en) ram[poke_a] <= poke_d;
      else if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
      mem_din <= ram[mem_a[17:0]];
    end
  end
  always @(posedge clk) if (mem_wr) wr_cnt <= wr_cnt + 1;
  always @(negedge clk) begin
    if (if_done) ifd_cnt++;
    if (lsb_done) lsd_cnt++;
  end
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    poke_a = a[17:0];
    poke_d = d;
    poke_en = 1'b1;
    ref_mem[a[17:0]] = d;
    step();
    poke_en = 1'b0;
  endtask
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int len);
    logic [31:0] r = '0, a;
    for (int i = 0; i < len; i++) begin
      a = addr + 32'(i);
      r[8*i +: 8] = ref_mem[a[17:0]];
    end
    return r;
  endfunction
  task automatic ref_store(input logic [31:0] addr, input int len, input logic [31:0] d);
    logic [31:0] a;
    for (int i = 0; i < len; i++) begin
      a = addr + 32'(i);
      ref_mem[a[17:0]] = d[8*i +: 8];
    end
  endtask
  task automatic ls_txn(input logic wr, input logic [31:0] addr, input int len, input logic [31:0] data, input string tag);
    int lat, w0, d0;
    logic [31:0] exp, a;
    exp = ref_load(addr, len);
    step();
    lsb_en = 1'b1;
    lsb_wr = wr;
    lsb_addr = addr;
    lsb_len = 3'(len);
    lsb_w_data = data;
    w0 = wr_cnt;
    d0 = lsd_cnt;
    lat = 0;
    do begin step(); lat++; end while (!lsb_done && lat < 300);
    chk({tag, ".lat"}, 512'(lat), 512'(wr ? len + 1 : len + 2));
    if (!wr) chk({tag, ".data"}, 512'(lsb_r_data), 512'(exp));
    step();
    lsb_en = 1'b0;
    chk({tag, ".pulse"}, 512'(lsb_done), 512'(0));
    repeat (8) step();
    chk({tag, ".ndone"}, 512'(lsd_cnt - d0), 512'(1));
    chk({tag, ".nwr"}, 512'(wr_cnt - w0), 512'(wr ? len : 0));
    if (wr) begin
      ref_store(addr, len, data);
      for (int i = 0; i < 5; i++) begin
        a = addr + 32'(i);
        chk({tag, ".ram"}, 512'(ram[a[17:0]]), 512'(ref_mem[a[17:0]]));
      end
    end
  endtask
  task automatic if_txn(input logic [31:0] pc, input int frz, input string tag);
    int lat, d0;
    logic [IF_DATA_WID-1:0] exp;
    logic [31:0] a;
    for (int k = 0; k < IF_LINE_BYTES; k++) begin
      a = pc + 32'(k);
      exp[8*k +: 8] = ref_mem[a[17:0]];
    end
    step();
    if_en = 1'b1;
    if_pc = pc;
    d0 = ifd_cnt;
    lat = 0;
    do begin
      step();
      lat++;
      rdy = !(frz > 0 && lat >= frz && lat < frz + 5);
    end while (!if_done && lat < 400);
    rdy = 1'b1;
    chk({tag, ".done"}, 512'(if_done), 512'(1));
    if (frz == 0) chk({tag, ".lat"}, 512'(lat), 512'(66));
    chk({tag, ".data"}, if_data, exp);
    step();
    if_en = 1'b0;
    chk({tag, ".pulse"}, 512'(if_done), 512'(0));
    repeat (8) step();
    chk({tag, ".ndone"}, 512'(ifd_cnt - d0), 512'(1));
  endtask
  initial begin
    int lat, d0, w0, k;
    logic [IF_DATA_WID-1:0] line0;
    for (int i = 0; i < 262144; i++) ref_mem[i] = init_byte(i);
    repeat (3) step();
    chk("rst.if_done", 512'(if_done), 512'(0));
    chk("rst.lsb_done", 512'(lsb_done), 512'(0));
    chk("rst.if_data", if_data, 512'(0));
    chk("rst.lsb_r_data", 512'(lsb_r_data), 512'(0));
    chk("rst.mem_wr", 512'(mem_wr), 512'(0));
    chk("rst.mem_a", 512'(mem_a), 512'(0));
    chk("rst.mem_dout", 512'(mem_dout), 512'(0));
    rst = 1'b0;
    for (int i = 0; i < 64; i++) poke(32'h1000 + 32'(i), 8'(i));
    poke(32'h200, 8'h78);
    poke(32'h201, 8'h56);
    poke(32'h202, 8'h34);
    poke(32'h203, 8'h12);
    if_txn(32'h1000, 0, "fill");
    chk("fill.word0", 512'(if_data[31:0]), 512'(32'h03020100));
    line0 = if_data;
    ls_txn(1'b0, 32'h200, 4, 32'h0, "ldw");
    chk("ldw.val", 512'(lsb_r_data), 512'(32'h12345678));
    ls_txn(1'b0, 32'h200, 1, 32'h0, "ldb");
    chk("ldb.val", 512'(lsb_r_data), 512'(32'h00000078));
    ls_txn(1'b1, 32'h300, 2, 32'hAABBCCDD, "sth");
    chk("sth.b0", 512'(ram[18'h300]), 512'(8'hDD));
    chk("sth.b1", 512'(ram[18'h301]), 512'(8'hCC));
    ls_txn(1'b0, 32'hFFFF_FFFF, 2, 32'h0, "ldwrap");
    ls_txn(1'b1, 32'hFFFF_FFFE, 4, 32'h1122_3344, "stwrap");
    step();
    lsb_en = 1'b1;
    lsb_wr = 1'b0;
    lsb_addr = 32'h200;
    lsb_len = 3'd4;
    if_en = 1'b1;
    if_pc = 32'h1000;
    d0 = ifd_cnt;
    w0 = lsd_cnt;
    lat = 0;
    do begin step(); lat++; end while (!lsb_done && lat < 300);
    chk("arb.ls_lat", 512'(lat), 512'(6));
    chk("arb.ls_data", 512'(lsb_r_data), 512'(32'h12345678));
    step();
    lat++;
    lsb_en = 1'b0;
    while (!if_done && lat < 400) begin step(); lat++; end
    chk("arb.if_lat", 512'(lat), 512'(73));
    chk("arb.if_data", if_data, line0);
    step();
    if_en = 1'b0;
    repeat (8) step();
    chk("arb.n_if", 512'(ifd_cnt - d0), 512'(1));
    chk("arb.n_ls", 512'(lsd_cnt - w0), 512'(1));
    step();
    if_en = 1'b1;
    if_pc = 32'h2000;
    d0 = ifd_cnt;
    repeat (20) step();
    if_en = 1'b0;
    lsb_en = 1'b1;
    lsb_wr = 1'b0;
    lsb_addr = 32'h200;
    lsb_len = 3'd2;
    lat = 0;
    do begin step(); lat++; end while (!lsb_done && lat < 300);
    chk("abn.ls_lat", 512'(lat), 512'(5));
    chk("abn.ls_data", 512'(lsb_r_data), 512'(32'h00005678));
    step();
    lsb_en = 1'b0;
    repeat (70) step();
    chk("abn.no_if_done", 512'(ifd_cnt - d0), 512'(0));
    if_txn(32'h1000, 31, "frz");
    chk("frz.same", if_data, line0);
    step();
    io_buffer_full = 1'b1;
    lsb_en = 1'b1;
    lsb_wr = 1'b1;
    lsb_addr = 32'h30000;
    lsb_len = 3'd1;
    lsb_w_data = 32'h0000_005A;
    w0 = wr_cnt;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("io.stall_wr", 512'(mem_wr), 512'(0));
      chk("io.stall_a", 512'(mem_a), 512'(0));
    end
    step();
    io_buffer_full = 1'b0;
    #1;
    chk("io.wr", 512'(mem_wr), 512'(1));
    chk("io.a", 512'(mem_a), 512'(32'h30000));
    chk("io.dout", 512'(mem_dout), 512'(8'h5A));
    step();
    chk("io.done", 512'(lsb_done), 512'(1));
    step();
    lsb_en = 1'b0;
    ref_store(32'h30000, 1, 32'h5A);
    chk("io.ram", 512'(ram[18'h30000]), 512'(ref_mem[18'h30000]));
    chk("io.nwr", 512'(wr_cnt - w0), 512'(1));
    io_buffer_full = 1'b1;
    ls_txn(1'b1, 32'h10010, 4, 32'hCAFE_F00D, "nonio_full");
    io_buffer_full = 1'b0;
    step();
    if_en = 1'b1;
    if_pc = 32'h1000;
    d0 = ifd_cnt;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    if_en = 1'b0;
    chk("mrst.mem_a", 512'(mem_a), 512'(0));
    chk("mrst.if_done", 512'(if_done), 512'(0));
    repeat (70) step();
    chk("mrst.no_done", 512'(ifd_cnt - d0), 512'(0));
    for (int t = 0; t < 24; t++) begin
      k = $urandom_range(0, 3);
      lat = $urandom_range(0, 2);
      if (k == 0) if_txn($urandom & 32'hFFFF_FFC0, 0, "rnd_if");
      else ls_txn(k == 1, $urandom, lat == 0 ? 1 : lat == 1 ? 2 : 4, $urandom, k == 1 ? "rnd_st" : "rnd_ld");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
